// File: rtl/limb_loader_pkg.sv
// Shared types and constants for the Limb program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package limb_loader_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM
  } loader_state_t;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Instruction words are always four bytes wide.
  localparam int BYTES_PER_WORD = 4;

  // LEN = 0 encodes a full 256-word frame.
  function automatic logic [8:0] word_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/limb_word_packer.sv
// Packs four bytes little-endian into one word (first byte lands in bits 7:0).
// Latency: word_next is combinational; word/full update on the load edge.
// Backpressure: none; the caller only pulses load on an accepted byte.
module limb_word_packer
  import limb_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_next,
  output logic [1:0]        byte_idx,
  output logic              full
);

  logic [DATA_W-1:0] word;

  // New bytes enter at the top and shift down, so after four loads the
  // first byte sits in bits 7:0.
  always_comb begin
    word_next = {byte_in, word[DATA_W-1:8]};
  end

  // Shift register plus byte position; clear restarts a word without
  // touching the data bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_idx <= 2'd0;
      full     <= 1'b0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      full     <= 1'b0;
    end else if (load) begin
      word     <= word_next;
      byte_idx <= byte_idx + 2'd1;
      full     <= (byte_idx == 2'(BYTES_PER_WORD - 1));
    end
  end

endmodule

// File: rtl/limb_loader.sv
// Limb program loader: framed bytes -> 32-bit words written from address 0; holds CPU until checksum passes.
// Latency: write strobe one cycle after a word's 4th byte; done/cpu_hold release one cycle after CSUM.
// Backpressure: in_ready drops only in the WRITE cycle; in_valid low stalls the FSM in place.
module limb_loader
  import limb_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_t state, next_state;

  logic              accept;
  logic              last_byte;
  logic [8:0]        word_cnt;
  logic [7:0]        sum;
  logic [DATA_W-1:0] pk_word_next;
  logic [1:0]        pk_byte_idx;
  logic              pk_full;

  limb_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state == LEN) || (state == WRITE)),
    .load     (accept && (state == DATA)),
    .byte_in  (in_data),
    .word_next(pk_word_next),
    .byte_idx (pk_byte_idx),
    .full     (pk_full)
  );

  // Handshake decode: the only non-accepting state is WRITE.
  always_comb begin
    in_ready  = (state != WRITE);
    accept    = in_valid && in_ready;
    last_byte = accept && (state == DATA) && (pk_byte_idx == 2'(BYTES_PER_WORD - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; SYNC_BYTE only matters while idle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && (in_data == SYNC_BYTE)) next_state = LEN;
      LEN:     if (accept) next_state = DATA;
      DATA:    if (last_byte) next_state = WRITE;
      WRITE:   next_state = (word_cnt == 9'd1) ? CSUM : DATA;
      CSUM:    if (accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counters, checksum and registered outputs. The address may roll to 0
  // after the 256th word, but the count has already sent us to CSUM, so no
  // write ever follows address FF within a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= 9'd0;
      sum       <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= last_byte;
      done   <= 1'b0;
      busy   <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        LEN: begin
          if (accept) begin
            word_cnt <= word_count(in_data);
            sum      <= in_data;
            mem_addr <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            sum <= sum + in_data;
            if (last_byte) mem_wdata <= pk_word_next;
          end
        end
        WRITE: begin
          if (pk_full) begin
            mem_addr <= mem_addr + 1'b1;
            word_cnt <= word_cnt - 9'd1;
          end
        end
        CSUM: begin
          if (accept) begin
            if (8'(sum + in_data) == 8'h00) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_limb_loader.sv
// Scoreboard bench for limb_loader: stimulus pushes expected writes/results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_limb_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  limb_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  int last_gap = 0;
  int wr_count = 0;
  int bad_ready = 0;
  logic prev_error = 1'b0;

  logic [39:0] exp_wr[$];   // {addr, data}
  bit          exp_res[$];  // 1 = good frame expected

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every write and every frame outcome against the queues.
  always @(negedge clk) begin
    logic [39:0] e;
    bit r;
    if (reset) begin
      prev_error = 1'b0;
    end else begin
      if (in_ready !== !mem_we) bad_ready++;
      if (mem_we === 1'b1) begin
        last_gap    = cyc - last_we_cyc;
        last_we_cyc = cyc;
        wr_count++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL write_unexpected: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
          check("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (done === 1'b1) begin
        if (exp_res.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: got done=1 expected no outcome");
        end else begin
          r = exp_res.pop_front();
          check("outcome_good", 32'd1, {31'd0, r});
          check("done_cpu_hold", {31'd0, cpu_hold}, 32'd0);
          check("done_error", {31'd0, error}, 32'd0);
        end
      end
      if (error === 1'b1 && prev_error === 1'b0) begin
        if (exp_res.size() == 0) begin
          tests++; fails++;
          $display("FAIL error_unexpected: got error rise expected no outcome");
        end else begin
          r = exp_res.pop_front();
          check("outcome_bad", 32'd0, {31'd0, r});
          check("err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
          check("err_no_done", {31'd0, done}, 32'd0);
        end
      end
      prev_error = error;
    end
  end

  // Offer one byte and hold it until accepted; waited = cycles with in_ready low.
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 20) begin
        tests++; fails++;
        $display("FAIL send_timeout: got in_ready low for %0d cycles expected acceptance", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input logic [7:0] base, input int j);
    return 8'(int'(base) + 17 * j);
  endfunction

  // Build and send a frame; data byte j = base + 0x11*j. Expected writes and
  // outcome are queued before the first byte goes out.
  task automatic run_frame(input logic [7:0] lenb, input logic [7:0] base,
                           input bit corrupt, input int stall_at);
    int n, w;
    logic [7:0] sum, csum;
    logic [31:0] word;
    n   = (lenb == 8'd0) ? 256 : int'(lenb);
    sum = lenb;
    for (int i = 0; i < n; i++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        word[8*k +: 8] = pat(base, 4*i + k);
        sum = sum + pat(base, 4*i + k);
      end
      exp_wr.push_back({8'(i), word});
    end
    csum = 8'(0) - sum;
    if (corrupt) csum = csum + 8'd1;
    exp_res.push_back(!corrupt);
    send_byte(8'hA5, w);
    send_byte(lenb, w);
    for (int j = 0; j < 4*n; j++) begin
      if (j == stall_at) idle(3);
      send_byte(pat(base, j), w);
    end
    send_byte(csum, w);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
    check({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
    check({tag, "_mem_addr"},  {24'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
    check({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy},     32'd0);
    check({tag, "_done"},      {31'd0, done},     32'd0);
    check({tag, "_error"},     {31'd0, error},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w, wc;
    logic [7:0] garbage [3];
    garbage[0] = 8'h00; garbage[1] = 8'hFF; garbage[2] = 8'h3C;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #12;
    check_reset_values("por");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Good one-word frame: A5 01 11 22 33 44 55
    run_frame(8'h01, 8'h11, 1'b0, -1);
    idle(3);
    check("good_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("good_busy", {31'd0, busy}, 32'd0);
    check("good_error", {31'd0, error}, 32'd0);

    // Same frame with CSUM 56
    run_frame(8'h01, 8'h11, 1'b1, -1);
    idle(3);
    check("bad_error", {31'd0, error}, 32'd1);
    check("bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);

    // Idle garbage is swallowed without writes, then a normal frame
    wc = wr_count;
    for (int i = 0; i < 3; i++) begin
      send_byte(garbage[i], w);
      check("garbage_wait", w, 0);
    end
    idle(2);
    check("garbage_busy", {31'd0, busy}, 32'd0);
    check("garbage_writes", wr_count - wc, 0);
    run_frame(8'h01, 8'h3C, 1'b0, -1);
    idle(3);
    check("reload_error_cleared", {31'd0, error}, 32'd0);
    check("reload_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // Two words back to back: writes 5 cycles apart
    run_frame(8'h02, 8'h01, 1'b0, -1);
    idle(3);
    check("word_spacing", last_gap, 5);

    // Two words with a stall in the middle of the second word
    run_frame(8'h02, 8'h90, 1'b0, 6);
    idle(3);
    check("stall_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // LEN = 0: 256 words, addresses 00..FF
    wc = wr_count;
    run_frame(8'h00, 8'h07, 1'b0, -1);
    idle(3);
    check("len0_writes", wr_count - wc, 256);
    check("len0_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // Reset after two data bytes
    send_byte(8'hA5, w);
    send_byte(8'h02, w);
    send_byte(8'h11, w);
    send_byte(8'h22, w);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    reset = 1'b1;
    #2;
    check_reset_values("mid_rst");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_frame(8'h01, 8'h5A, 1'b0, -1);
    idle(5);
    check("post_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    check("writes_left", exp_wr.size(), 0);
    check("outcomes_left", exp_res.size(), 0);
    check("in_ready_vs_write", bad_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/limb_loader.md
# limb_loader

Program loader for the Limb CPU: receives a framed byte stream, packs it into 32-bit instruction words, and writes them sequentially into Limb program memory starting at address 0. It holds the CPU in reset while loading. It releases the CPU only after a frame's checksum verifies. It sits between the host byte link and the program-memory write port, and is the writer counterpart to the CPU's instruction fetch.

## Interface
Parameters:
- ADDR_W, 8, program-memory address width (256 words).
- DATA_W, 32, instruction word width; fixed at 4 bytes.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock. One clock domain.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts the byte; a transfer occurs when in_valid && in_ready on a rising clk edge.
- mem_we  out  1  program-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_hold  out  1  drives the CPU reset; high while the CPU must not run.
- busy  out  1  a frame is in progress (state is not IDLE).
- done  out  1  one-cycle pulse when a frame completes with a good checksum.
- error  out  1  sticky checksum-failure flag.

## Operation
- Frame format: SYNC_BYTE, then LEN, then 4×N data bytes, then CSUM.
  - N = LEN, except LEN = 0 means N = 256.
  - Each word is little-endian: the first byte lands in bits 7:0, the fourth byte in bits 31:24.
- Checksum: the 8-bit sum (mod 256) of LEN, all data bytes and CSUM must equal 8'h00.
- FSM states:
  - IDLE: any byte other than SYNC_BYTE is accepted and discarded. On accepting SYNC_BYTE: clear error, set cpu_hold = 1, go to LEN.
  - LEN: accept one byte. Set word count = (LEN == 0) ? 256 : LEN (9-bit), set sum = LEN, set address = 0, set byte index = 0. Go to DATA.
  - DATA: accept a byte, shift it into the word register, add it to sum, increment the byte index. After the 4th byte, go to WRITE.
  - WRITE: in_ready = 0. Assert mem_we with the current address and the packed word. Then increment the address and decrement the word count. Go to CSUM if the count reaches 0, otherwise go to DATA.
  - CSUM: accept a byte. If (sum + byte) mod 256 == 0: pulse done, set cpu_hold = 0. Otherwise: set error = 1, keep cpu_hold = 1. Return to IDLE.
- An address wrap is impossible by construction: 256 words ends at address 8'hFF. The address counter must never write past 8'hFF within a frame.
- Words are written before the checksum verifies. This is acceptable because the CPU stays held. A failed frame leaves the memory partially updated and cpu_hold = 1.
- A new SYNC_BYTE arriving in IDLE after a successful load re-asserts cpu_hold and starts a reload.
- SYNC_BYTE values inside LEN, DATA or CSUM are treated as ordinary data.

## Timing
- Reset values: state = IDLE, in_ready = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 1, busy = 0, done = 0, error = 0.
- All outputs are registered, except in_ready, which is a decode of the current state (0 only in WRITE).
- mem_we is high for exactly the one cycle in WRITE. It appears the cycle after the 4th byte's handshake.
- Throughput: 5 cycles per word with in_valid held high.
- done and the cpu_hold release happen in the cycle after the CSUM handshake. error is set in that same cycle on a mismatch.
- in_valid low stalls the FSM in place without losing state.
- Asserting reset mid-frame returns the FSM to IDLE immediately with the values above. Memory contents already written are not touched.

## Structure
- limb_loader_pkg holds:
  - the state enum typedef `loader_state_t` (IDLE, LEN, DATA, WRITE, CSUM);
  - the SYNC_BYTE default;
  - the BYTES_PER_WORD = 4 constant.
- One sub-module, `limb_word_packer`: a 4-byte little-endian shift/pack register with a byte index and a `full` flag. The top level owns the FSM, the counters and the checksum.

## Test plan
- Good one-word frame: send A5, 01, 11, 22, 33, 44, 55.
  - Expect one mem_we with mem_addr = 00 and mem_wdata = 32'h44332211.
  - Then expect done pulsed once, cpu_hold = 0 and error = 0.
- Bad checksum: the same frame with CSUM = 56.
  - Expect the same single write, then error = 1, cpu_hold = 1 and no done pulse.
- Idle garbage then frame: send 00, FF, 3C, then a good frame.
  - Expect the garbage bytes consumed with in_ready = 1 and no writes.
  - Expect the frame to load normally.
- LEN = 0: 1024 data bytes plus a correct CSUM.
  - Expect 256 writes at addresses 00..FF in order, no write past FF, then done.
- Backpressure and stall: hold in_valid high for a 2-word frame.
  - Expect in_ready = 0 only in each WRITE cycle and words spaced 5 cycles apart.
  - Deassert in_valid mid-word and expect correct packing on resume.
- Reset mid-DATA: assert reset after 2 data bytes.
  - Expect all outputs at their reset values.
  - Then a fresh good frame loads correctly from address 00.
